ksa_pipe_adder: RTL and testbench
=================================

KSA_PIPE_ADDER -- requirements
Module: ksa_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be a power of two in 8..64.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, synchronous, active-high reset.
REQ-005 Port in_valid, input, 1, an operand beat is offered.
REQ-006 Port in_ready, output, 1, the block accepts a beat this cycle.
REQ-007 Port A, input, WIDTH, operand A.
REQ-008 Port B, input, WIDTH, operand B.
REQ-009 Port Cin, input, 1, carry-in (not-borrow-in when subtracting).
REQ-010 Port Sub, input, 1, mode select: 0 = add, 1 = subtract.
REQ-011 Port in_tag, input, TAG_W, sideband tag.
REQ-012 Port out_valid, output, 1, a result beat is present.
REQ-013 Port out_ready, input, 1, the consumer accepts the result.
REQ-014 Port Sum, output, WIDTH, result.
REQ-015 Port Cout, output, 1, carry-out of the MSB.
REQ-016 Port Ovf, output, 1, two's-complement signed overflow.
REQ-017 Port Zero, output, 1, asserted when Sum == 0.
REQ-018 Port out_tag, output, TAG_W, the tag of the result beat.

Function
REQ-019 The block SHALL compute {Cout,Sum} = A + (Sub ? ~B : B) + Cin, exactly WIDTH+1 bits; no Cin override in subtract mode, so a plain subtract needs Cin=1 and wider subtracts can be chained.
REQ-020 Ovf SHALL equal (A[MSB] == B'[MSB]) && (Sum[MSB] != A[MSB]), where B' is the post-inversion operand.
REQ-021 The carry network SHALL be Kogge-Stone parallel prefix with LEVELS = clog2(WIDTH) levels.
REQ-022 The pipeline SHALL have LAT = LEVELS+2 register stages:
  - stage 0: registered P/G generation, with Cin folded in as G[-1]
  - one register per prefix level
  - an output register holding Sum, Cout, Ovf, Zero and out_tag
REQ-023 A beat transferred (in_valid && in_ready) at edge n SHALL present out_valid=1 with its result after edge n+LAT-1, provided no stall occurs. For WIDTH=32, LAT=7.
REQ-024 Each stage SHALL carry a valid bit; tags and results SHALL emerge in acceptance order.
REQ-025 Stall SHALL be defined as out_valid && !out_ready; during a stall every stage register, including the valid bits, SHALL hold its value.
REQ-026 in_ready SHALL equal !rst && (!out_valid || out_ready), combinational from these signals only, with no dependence on in_valid.
REQ-027 Outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 With in_valid and out_ready held high, throughput SHALL be one beat per cycle.
REQ-029 Bubbles (invalid stages) SHALL advance normally when not stalled; bubble compaction is not required.
REQ-030 A beat offered while in_ready=0 SHALL NOT be captured.

Reset
REQ-031 While rst=1, all stage valid bits and data registers SHALL clear at the clock edge.
REQ-032 After that edge: out_valid=0, Sum=0, Cout=0, Ovf=0, Zero=0, out_tag=0, and in_ready=0 while rst remains high.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight beats; no result for a beat accepted before reset SHALL ever appear.
REQ-034 The first edge with rst=0 MAY accept a beat; in_ready=1 in that cycle.

Structure
REQ-035 Shared package ksa_pkg SHALL hold:
  - the clog2 constant function
  - the LAT derivation
  - the op-mode enum (ADD, SUB)
  - the P/G pair struct
REQ-036 One sub-module, ksa_prefix_level, SHALL implement a single prefix level (distance parameter, black/buffer cells, stall-enabled register and valid bit), instantiated LEVELS times via generate.
REQ-037 The bench SHALL compare every result against a behavioural A + B' + Cin model and run at WIDTH=32 and WIDTH=8.

Verification
REQ-038 WIDTH=32: A=FFFFFFFF, B=00000001, Cin=0, Sub=0 -> Sum=00000000, Cout=1, Zero=1, Ovf=0, out_valid exactly 7 cycles after acceptance.
REQ-039 A=7FFFFFFF, B=00000001, Cin=0, Sub=0 -> Sum=80000000, Cout=0, Ovf=1.
REQ-040 Sub=1, A=00000005, B=00000007, Cin=1 -> Sum=FFFFFFFE, Cout=0, Ovf=0, Zero=0; then A=B=12345678 -> Sum=0, Cout=1, Zero=1.
REQ-041 Stream 10 beats with tags 0..9 back-to-back, drop out_ready for 3 cycles mid-stream:
  - in_ready is low during the stall
  - outputs are held stable during the stall
  - all 10 results arrive in tag order, none lost or duplicated
REQ-042 Accept 4 beats, assert rst for 1 cycle at the 3rd cycle -> out_valid=0 and all outputs 0 after that edge; none of the 4 results ever appear; a new beat after reset completes normally.
REQ-043 WIDTH=8: A=FF, B=01, Cin=0 -> Sum=00, Cout=1, latency 5; plus an exhaustive 4-bit LSB sweep of a, b in 0..15 and Cin in {0,1}, all matching the behavioural model.

Source files
------------

// File: rtl/ksa_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
package ksa_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // P/G generation register + one register per prefix level + output register
  function automatic int lat_of(input int width);
    return clog2(width) + 2;
  endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// One Kogge-Stone prefix level: black cells at distance DIST, buffers below it,
// followed by a stall-enabled register for group P/G, sideband and valid.
module ksa_prefix_level
  import ksa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1,
  parameter int SB_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              vld_i,
  input  pg_t  [WIDTH-1:0]  pg_i,
  input  logic [SB_W-1:0]   sb_i,
  output logic              vld_o,
  output pg_t  [WIDTH-1:0]  pg_o,
  output logic [SB_W-1:0]   sb_o
);

  pg_t [WIDTH-1:0] pg_d;
  pg_t [WIDTH-1:0] pg_q;
  logic [SB_W-1:0] sb_q;
  logic            vld_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (i >= DIST) begin : g_black
      assign pg_d[i] = '{g: pg_i[i].g | (pg_i[i].p & pg_i[i-DIST].g),
                         p: pg_i[i].p & pg_i[i-DIST].p};
    end else begin : g_buf
      assign pg_d[i] = pg_i[i];
    end
  end

  // ---- level register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      pg_q  <= '0;
      sb_q  <= '0;
    end else if (en_i) begin
      vld_q <= vld_i;
      pg_q  <= pg_d;
      sb_q  <= sb_i;
    end
  end

  assign vld_o = vld_q;
  assign pg_o  = pg_q;
  assign sb_o  = sb_q;

endmodule

// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone add/subtract with ready/valid flow control and a
// sideband tag; Cin is folded into bit 0's generate so the prefix tree spans WIDTH bits.
module ksa_pipe_adder
  import ksa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LAT    = lat_of(WIDTH);
  localparam int LEVELS = LAT - 2;
  localparam int MSB    = WIDTH - 1;
  // sideband = {tag, A msb, Cin, half-sum}
  localparam int SB_W   = TAG_W + WIDTH + 2;

  logic             stall;
  logic             advance;
  logic             accept;
  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] hp_d;

  pg_t  [WIDTH-1:0] pg_p0_d;
  pg_t  [WIDTH-1:0] pg_p0_q;
  logic [SB_W-1:0]  sb_p0_d;
  logic [SB_W-1:0]  sb_p0_q;
  logic             vld_p0_q;

  pg_t  [WIDTH-1:0] pg_lvl  [0:LEVELS];
  logic [SB_W-1:0]  sb_lvl  [0:LEVELS];
  logic             vld_lvl [0:LEVELS];

  logic [WIDTH-1:0] hp_f;
  logic [WIDTH-1:0] carry_f;
  logic             cin_f;
  logic             amsb_f;
  logic             bmsb_f;
  logic [TAG_W-1:0] tag_f;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             zero_d;

  logic             vld_out_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic [TAG_W-1:0] tag_q;

  assign stall    = vld_out_q && !out_ready;
  assign advance  = !stall;
  assign in_ready = !rst && (!vld_out_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign op      = op_e'(Sub);
  assign b_eff   = (op == OP_SUB) ? ~B : B;
  assign hp_d    = A ^ b_eff;
  assign sb_p0_d = {in_tag, A[MSB], Cin, hp_d};

  always_comb begin
    pg_p0_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pg_p0_d[i].g = A[i] & b_eff[i];
      pg_p0_d[i].p = hp_d[i];
    end
    // bit 0 absorbs Cin; its group never propagates beyond the carry-in
    pg_p0_d[0].g = (A[0] & b_eff[0]) | (hp_d[0] & Cin);
    pg_p0_d[0].p = 1'b0;
  end

  // ---- stage 0: P/G generation register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      pg_p0_q  <= '0;
      sb_p0_q  <= '0;
    end else if (advance) begin
      vld_p0_q <= accept;
      pg_p0_q  <= pg_p0_d;
      sb_p0_q  <= sb_p0_d;
    end
  end

  assign pg_lvl[0]  = pg_p0_q;
  assign sb_lvl[0]  = sb_p0_q;
  assign vld_lvl[0] = vld_p0_q;

  // ---- prefix levels ----
  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    ksa_prefix_level #(
      .WIDTH(WIDTH),
      .DIST (1 << l),
      .SB_W (SB_W)
    ) u_level (
      .clk  (clk),
      .rst  (rst),
      .en_i (advance),
      .vld_i(vld_lvl[l]),
      .pg_i (pg_lvl[l]),
      .sb_i (sb_lvl[l]),
      .vld_o(vld_lvl[l+1]),
      .pg_o (pg_lvl[l+1]),
      .sb_o (sb_lvl[l+1])
    );
  end

  assign hp_f   = sb_lvl[LEVELS][WIDTH-1:0];
  assign cin_f  = sb_lvl[LEVELS][WIDTH];
  assign amsb_f = sb_lvl[LEVELS][WIDTH+1];
  assign tag_f  = sb_lvl[LEVELS][SB_W-1 -: TAG_W];

  always_comb begin
    carry_f    = '0;
    carry_f[0] = cin_f;
    for (int i = 1; i < WIDTH; i++) begin
      carry_f[i] = pg_lvl[LEVELS][i-1].g;
    end
    cout_d = pg_lvl[LEVELS][MSB].g;
    sum_d  = hp_f ^ carry_f;
    bmsb_f = hp_f[MSB] ^ amsb_f;
    ovf_d  = (amsb_f == bmsb_f) && (sum_d[MSB] != amsb_f);
    zero_d = ~|sum_d;
  end

  // ---- output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_out_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      tag_q     <= '0;
    end else if (advance) begin
      vld_out_q <= vld_lvl[LEVELS];
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
      tag_q     <= tag_f;
    end
  end

  assign out_valid = vld_out_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Bench for ksa_pipe_adder at WIDTH=32 and WIDTH=8 with a queue scoreboard
// fed by a behavioural A + B' + Cin model.
module tb_ksa_pipe_adder;

  localparam int LAT32 = 7;
  localparam int LAT8  = 5;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [31:0] a32, b32, sum32;
  logic        cin32, sub32, iv32, ir32, ov32, ordy32, cout32, ovf32, zero32;
  logic [3:0]  itag32, otag32;

  logic [7:0]  a8, b8, sum8;
  logic        cin8, sub8, iv8, ir8, ov8, ordy8, cout8, ovf8, zero8;
  logic [3:0]  itag8, otag8;

  exp_t q32[$];
  exp_t q8[$];
  int   checks   = 0;
  int   failures = 0;
  int   rcv32    = 0;
  int   rcv8     = 0;

  ksa_pipe_adder #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .A(a32), .B(b32), .Cin(cin32), .Sub(sub32), .in_tag(itag32),
    .out_valid(ov32), .out_ready(ordy32), .Sum(sum32), .Cout(cout32),
    .Ovf(ovf32), .Zero(zero32), .out_tag(otag32)
  );

  ksa_pipe_adder #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .Cin(cin8), .Sub(sub8), .in_tag(itag8),
    .out_valid(ov8), .out_ready(ordy8), .Sum(sum8), .Cout(cout8),
    .Ovf(ovf8), .Zero(zero8), .out_tag(otag8)
  );

  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub, input logic [3:0] tag);
    exp_t        m;
    logic [63:0] mask, bb;
    logic [64:0] full;
    mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    bb     = (sub ? ~b : b) & mask;
    full   = {1'b0, a & mask} + {1'b0, bb} + {64'd0, cin};
    m.sum  = full[63:0] & mask;
    m.cout = full[w];
    m.ovf  = (a[w-1] == bb[w-1]) && (m.sum[w-1] != a[w-1]);
    m.zero = (m.sum == 64'd0);
    m.tag  = tag;
    return m;
  endfunction

  // scoreboard: push on accepted beat, pop on delivered result
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q32.delete();
      q8.delete();
    end
    if (iv32 && ir32) q32.push_back(model(32, {32'd0, a32}, {32'd0, b32}, cin32, sub32, itag32));
    if (iv8 && ir8)   q8.push_back(model(8, {56'd0, a8}, {56'd0, b8}, cin8, sub8, itag8));
    if (ov32 === 1'b1 && ordy32) begin
      checks++;
      rcv32++;
      if (q32.size() == 0) begin
        failures++;
        $display("FAIL sb32_unexpected got sum=%h tag=%0d required no result", sum32, otag32);
      end else begin
        e = q32.pop_front();
        if ({sum32, cout32, ovf32, zero32, otag32} !== {e.sum[31:0], e.cout, e.ovf, e.zero, e.tag}) begin
          failures++;
          $display("FAIL sb32 got sum=%h c=%b v=%b z=%b tag=%0d required sum=%h c=%b v=%b z=%b tag=%0d",
                   sum32, cout32, ovf32, zero32, otag32, e.sum[31:0], e.cout, e.ovf, e.zero, e.tag);
        end
      end
    end
    if (ov8 === 1'b1 && ordy8) begin
      checks++;
      rcv8++;
      if (q8.size() == 0) begin
        failures++;
        $display("FAIL sb8_unexpected got sum=%h tag=%0d required no result", sum8, otag8);
      end else begin
        e = q8.pop_front();
        if ({sum8, cout8, ovf8, zero8, otag8} !== {e.sum[7:0], e.cout, e.ovf, e.zero, e.tag}) begin
          failures++;
          $display("FAIL sb8 got sum=%h c=%b v=%b z=%b tag=%0d required sum=%h c=%b v=%b z=%b tag=%0d",
                   sum8, cout8, ovf8, zero8, otag8, e.sum[7:0], e.cout, e.ovf, e.zero, e.tag);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Drives one beat into an idle pipeline; returns edges from acceptance to out_valid (0 if out_valid never rose).
  task automatic drive_one(input bit w8, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic [3:0] tag,
                           output int lat_seen);
    if (w8) begin
      a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sub; itag8 = tag; iv8 = 1'b1;
    end else begin
      a32 = a; b32 = b; cin32 = cin; sub32 = sub; itag32 = tag; iv32 = 1'b1;
    end
    @(posedge clk);
    #1;
    iv8  = 1'b0;
    iv32 = 1'b0;
    lat_seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if ((w8 ? ov8 : ov32) === 1'b1) begin
        lat_seen = k;
        break;
      end
    end
  endtask

  task automatic wait_drain(output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (q32.size() == 0 && q8.size() == 0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ov32, sum32, cout32, ovf32, zero32, otag32} !== 40'd0) begin
      failures++;
      $display("FAIL reset_out32 got v=%b sum=%h c=%b o=%b z=%b tag=%0d required all 0",
               ov32, sum32, cout32, ovf32, zero32, otag32);
    end
    checks++;
    if ({ov8, sum8, cout8, ovf8, zero8, otag8} !== 16'd0) begin
      failures++;
      $display("FAIL reset_out8 got v=%b sum=%h required all 0", ov8, sum8);
    end
    checks++;
    if ({ir32, ir8} !== 2'b00) begin
      failures++;
      $display("FAIL reset_in_ready got %b%b required 00", ir32, ir8);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ir32, ir8} !== 2'b11) begin
      failures++;
      $display("FAIL post_reset_in_ready got %b%b required 11", ir32, ir8);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_wrap();
    int k;
    drive_one(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h1, k);
    checks++;
    if (k !== LAT32 - 1) begin
      failures++;
      $display("FAIL lat32 got %0d edges required %0d", k, LAT32 - 1);
    end
    checks++;
    if ({sum32, cout32, zero32, ovf32} !== {32'h0000_0000, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_wrap got sum=%h c=%b z=%b o=%b required 00000000 1 1 0", sum32, cout32, zero32, ovf32);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ovf();
    int k;
    drive_one(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h2, k);
    checks++;
    if ({sum32, cout32, ovf32, zero32} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_ovf got sum=%h c=%b o=%b z=%b required 80000000 0 1 0", sum32, cout32, ovf32, zero32);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sub();
    int k;
    drive_one(1'b0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 4'h3, k);
    checks++;
    if ({sum32, cout32, ovf32, zero32} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL sub_neg got sum=%h c=%b o=%b z=%b required FFFFFFFE 0 0 0", sum32, cout32, ovf32, zero32);
    end
    @(posedge clk);
    #1;
    drive_one(1'b0, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 4'h4, k);
    checks++;
    if ({sum32, cout32, ovf32, zero32} !== {32'h0000_0000, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL sub_zero got sum=%h c=%b o=%b z=%b required 00000000 1 0 1", sum32, cout32, ovf32, zero32);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int   r0;
    bit   to;
    logic [39:0] snap;
    r0 = rcv32;
    fork
      begin
        int  t;
        int  cyc;
        bit  acc;
        t = 0;
        cyc = 0;
        iv32 = 1'b1;
        a32 = $urandom(); b32 = $urandom(); cin32 = 1'($urandom_range(0, 1));
        sub32 = 1'($urandom_range(0, 1)); itag32 = 4'(t);
        while (t < 10 && cyc < 100) begin
          @(negedge clk);
          acc = ir32;
          @(posedge clk);
          #1;
          cyc++;
          if (acc) begin
            t++;
            a32 = $urandom(); b32 = $urandom(); cin32 = 1'($urandom_range(0, 1));
            sub32 = 1'($urandom_range(0, 1)); itag32 = 4'(t);
          end
        end
        iv32 = 1'b0;
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        ordy32 = 1'b0;
        @(negedge clk);
        checks++;
        if ({ov32, ir32} !== 2'b10) begin
          failures++;
          $display("FAIL stall_entry got out_valid=%b in_ready=%b required 1 0", ov32, ir32);
        end
        snap = {sum32, cout32, ovf32, zero32, otag32};
        for (int i = 0; i < 2; i++) begin
          @(posedge clk);
          @(negedge clk);
          checks++;
          if (ir32 !== 1'b0) begin
            failures++;
            $display("FAIL stall_in_ready got %b required 0", ir32);
          end
          checks++;
          if ({sum32, cout32, ovf32, zero32, otag32} !== snap || ov32 !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold got %h v=%b required %h v=1", {sum32, cout32, ovf32, zero32, otag32}, ov32, snap);
          end
        end
        @(posedge clk);
        #1;
        ordy32 = 1'b1;
      end
    join
    wait_drain(to);
    checks++;
    if (to !== 1'b0 || (rcv32 - r0) !== 10) begin
      failures++;
      $display("FAIL stream_count got %0d results timeout=%b required 10", rcv32 - r0, to);
    end
  endtask

  task automatic test_reset_flush();
    int r0;
    int k;
    r0 = rcv32;
    iv32 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a32 = $urandom(); b32 = $urandom(); cin32 = 1'b0; sub32 = 1'b0; itag32 = 4'(8 + i);
      @(posedge clk);
      #1;
    end
    iv32 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ov32, sum32, cout32, ovf32, zero32, otag32, ir32} !== 41'd0) begin
      failures++;
      $display("FAIL flush_out got v=%b sum=%h c=%b o=%b z=%b tag=%0d rdy=%b required all 0",
               ov32, sum32, cout32, ovf32, zero32, otag32, ir32);
    end
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (rcv32 !== r0) begin
      failures++;
      $display("FAIL flush_discard got %0d stale results required 0", rcv32 - r0);
    end
    drive_one(1'b0, 32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b0, 4'hC, k);
    checks++;
    if (k !== LAT32 - 1) begin
      failures++;
      $display("FAIL flush_recover_lat got %0d required %0d", k, LAT32 - 1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rcv32 !== r0 + 1) begin
      failures++;
      $display("FAIL flush_recover_count got %0d required %0d", rcv32, r0 + 1);
    end
  endtask

  task automatic test_w8();
    int k;
    int r0;
    int not_ready;
    bit to;
    drive_one(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 4'h5, k);
    checks++;
    if (k !== LAT8 - 1) begin
      failures++;
      $display("FAIL lat8 got %0d edges required %0d", k, LAT8 - 1);
    end
    checks++;
    if ({sum8, cout8} !== {8'h00, 1'b1}) begin
      failures++;
      $display("FAIL add8_wrap got sum=%h c=%b required 00 1", sum8, cout8);
    end
    @(posedge clk);
    #1;
    r0 = rcv8;
    not_ready = 0;
    iv8 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          for (int s = 0; s < 2; s++) begin
            a8 = {4'($urandom_range(0, 15)), 4'(a)};
            b8 = {4'($urandom_range(0, 15)), 4'(b)};
            cin8 = 1'(c); sub8 = 1'(s); itag8 = 4'(a ^ b);
            @(negedge clk);
            if (ir8 !== 1'b1) not_ready++;
            @(posedge clk);
            #1;
          end
        end
      end
    end
    iv8 = 1'b0;
    wait_drain(to);
    checks++;
    if (not_ready !== 0) begin
      failures++;
      $display("FAIL sweep8_throughput got %0d not-ready cycles required 0", not_ready);
    end
    checks++;
    if (to !== 1'b0 || (rcv8 - r0) !== 1024) begin
      failures++;
      $display("FAIL sweep8_count got %0d timeout=%b required 1024", rcv8 - r0, to);
    end
  endtask

  initial begin
    rst = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; itag32 = '0; ordy32 = 1'b1;
    iv8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0; itag8  = '0; ordy8  = 1'b1;
    #1;
    test_reset();
    test_add_wrap();
    test_ovf();
    test_sub();
    test_back_to_back();
    test_reset_flush();
    test_w8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
